// File: rtl/wb_interconnect_nxm.sv
// wb_interconnect_nxm
//   Shared-bus Wishbone interconnect connecting NM masters to NS slaves.
//   A registered round-robin arbiter picks one master. The granted master's
//   address, byte selects, write enable and write data are broadcast to every
//   slave. Only the slave selected by adr[AW-1:MSK] sees cyc/stb. Responses
//   pass straight back to the owner with no added latency.
//   Strobes to unmapped slave indices get a one-cycle decode error.
//   A watchdog turns a slave that never responds into a one-cycle bus error.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   s_wb_*               upstream (master-facing) buses, master i in slice i
//   m_wb_*               downstream (slave-facing) broadcast plus per-slave cyc/stb
//   o_grant              one-hot owner of the bus (0 while idle)
//   o_timeout            one-cycle pulse when the watchdog fires
module wb_interconnect_nxm #(
  parameter int NM     = 2,
  parameter int NS     = 4,
  parameter int AW     = 32,
  parameter int DW     = 128,
  parameter int MSK    = 24,
  parameter int TO_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM*AW-1:0]     s_wb_adr,
  input  logic [NM*(DW/8)-1:0] s_wb_sel,
  input  logic [NM-1:0]        s_wb_we,
  input  logic [NM*DW-1:0]     s_wb_dat_i,
  output logic [NM*DW-1:0]     s_wb_dat_o,
  input  logic [NM-1:0]        s_wb_cyc,
  input  logic [NM-1:0]        s_wb_stb,
  output logic [NM-1:0]        s_wb_ack,
  output logic [NM-1:0]        s_wb_err,
  output logic [AW-1:0]        m_wb_adr,
  output logic [DW/8-1:0]      m_wb_sel,
  output logic                 m_wb_we,
  output logic [DW-1:0]        m_wb_dat_o,
  input  logic [NS*DW-1:0]     m_wb_dat_i,
  output logic [NS-1:0]        m_wb_cyc,
  output logic [NS-1:0]        m_wb_stb,
  input  logic [NS-1:0]        m_wb_ack,
  input  logic [NS-1:0]        m_wb_err,
  output logic [NM-1:0]        o_grant,
  output logic                 o_timeout
);

  localparam int SW  = DW / 8;
  localparam int GW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int SIW = (NS > 1) ? $clog2(NS) : 1;
  localparam int IW  = AW - MSK;
  // Wide enough to hold both the address index and NS without truncation.
  localparam int CW  = IW + 5;
  localparam int TW  = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_DECERR = 2'd2,
    ST_TOERR  = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [NM-1:0]   gnt_r, gnt_nxt_s;
  logic [GW-1:0]   gidx_r, gidx_nxt_s;
  logic [GW-1:0]   last_r, last_nxt_s;
  logic [GW-1:0]   pick_s;
  logic [TW-1:0]   wd_cnt_r, wd_nxt_s, wd_inc_s;
  logic [AW-1:0]   g_adr_s;
  logic [IW-1:0]   idx_s;
  logic [SIW-1:0]  sidx_s;
  logic            hit_s, g_cyc_s, g_stb_s, sl_ack_s, sl_err_s, stall_s, any_req_s;

  // Decode of the current owner's request and the selected slave's response.
  assign g_adr_s   = s_wb_adr[gidx_r*AW +: AW];
  assign g_cyc_s   = s_wb_cyc[gidx_r];
  assign g_stb_s   = s_wb_stb[gidx_r];
  assign idx_s     = g_adr_s[AW-1:MSK];
  assign hit_s     = (CW'(idx_s) < CW'(NS));
  assign sidx_s    = SIW'(idx_s);
  assign sl_ack_s  = hit_s & m_wb_ack[sidx_s];
  assign sl_err_s  = hit_s & m_wb_err[sidx_s];
  assign any_req_s = |s_wb_cyc;
  assign stall_s   = (state_r == ST_GRANT) && g_stb_s && hit_s && !sl_ack_s && !sl_err_s;
  assign wd_inc_s  = (wd_cnt_r == TW'(TO_CYC)) ? wd_cnt_r : wd_cnt_r + TW'(1);
  assign o_grant   = gnt_r;

  // Round-robin pick: walking downward leaves the nearest requester after last_r.
  always_comb begin
    pick_s = last_r;
    for (int k = NM; k >= 1; k--) begin
      pick_s = s_wb_cyc[GW'((int'(last_r) + k) % NM)] ? GW'((int'(last_r) + k) % NM) : pick_s;
    end
  end

  // Next-state logic for arbitration, error states and the watchdog.
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    gidx_nxt_s  = gidx_r;
    last_nxt_s  = last_r;
    wd_nxt_s    = '0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_GRANT;
          gnt_nxt_s   = NM'(1) << pick_s;
          gidx_nxt_s  = pick_s;
          last_nxt_s  = pick_s;
        end else begin
          gnt_nxt_s   = '0;
        end
      end
      ST_GRANT: begin
        if (!g_cyc_s) begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = '0;
        end else if (g_stb_s && !hit_s) begin
          state_nxt_s = ST_DECERR;
        end else if (stall_s) begin
          wd_nxt_s = wd_inc_s;
          // Fire on the cycle the count reaches TO_CYC so exactly TO_CYC strobe cycles elapse.
          if (wd_inc_s == TW'(TO_CYC)) begin
            state_nxt_s = ST_TOERR;
          end else begin
            state_nxt_s = ST_GRANT;
          end
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_DECERR: state_nxt_s = ST_GRANT;
      ST_TOERR:  state_nxt_s = ST_GRANT;
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = '0;
      end
    endcase
  end

  // Slave-side broadcast/strobe routing and master-side response routing.
  always_comb begin
    m_wb_adr   = '0;
    m_wb_sel   = '0;
    m_wb_we    = 1'b0;
    m_wb_dat_o = '0;
    m_wb_cyc   = '0;
    m_wb_stb   = '0;
    s_wb_ack   = '0;
    s_wb_err   = '0;
    s_wb_dat_o = '0;
    o_timeout  = 1'b0;
    case (state_r)
      ST_GRANT: begin
        m_wb_adr   = g_adr_s;
        m_wb_sel   = s_wb_sel[gidx_r*SW +: SW];
        m_wb_we    = s_wb_we[gidx_r];
        m_wb_dat_o = s_wb_dat_i[gidx_r*DW +: DW];
        if (hit_s) begin
          m_wb_cyc[sidx_s] = g_cyc_s;
          m_wb_stb[sidx_s] = g_stb_s;
          s_wb_ack[gidx_r] = sl_ack_s;
          s_wb_err[gidx_r] = sl_err_s;
          s_wb_dat_o[gidx_r*DW +: DW] = m_wb_dat_i[sidx_s*DW +: DW];
        end else begin
          // Unmapped: nothing strobed; the error is reported from DECERR next cycle.
          s_wb_err[gidx_r] = 1'b0;
        end
      end
      ST_DECERR: begin
        m_wb_adr   = g_adr_s;
        m_wb_sel   = s_wb_sel[gidx_r*SW +: SW];
        m_wb_we    = s_wb_we[gidx_r];
        m_wb_dat_o = s_wb_dat_i[gidx_r*DW +: DW];
        s_wb_err[gidx_r] = 1'b1;
      end
      ST_TOERR: begin
        // cyc/stb stay low so the hung slave is abandoned; any late ack is dropped.
        m_wb_adr   = g_adr_s;
        m_wb_sel   = s_wb_sel[gidx_r*SW +: SW];
        m_wb_we    = s_wb_we[gidx_r];
        m_wb_dat_o = s_wb_dat_i[gidx_r*DW +: DW];
        s_wb_err[gidx_r] = 1'b1;
        o_timeout        = 1'b1;
      end
      default: begin
        m_wb_cyc = '0;
      end
    endcase
  end

  // State, grant, round-robin pointer and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      gnt_r    <= '0;
      gidx_r   <= '0;
      last_r   <= GW'(NM - 1);
      wd_cnt_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      gnt_r    <= gnt_nxt_s;
      gidx_r   <= gidx_nxt_s;
      last_r   <= last_nxt_s;
      wd_cnt_r <= wd_nxt_s;
    end
  end

endmodule

// File: doc/wb_interconnect_nxm.md
Name: wb_interconnect_nxm

Overview:
- Parametrised Wishbone shared-bus interconnect; successor to the fixed single-master crossbar used in the FPGA top.
- Connects NM masters (core, DMA, debug) to NS slaves (SRAM, GPIO, UART, ...).
- Round-robin arbitration, address decode on the upper address bits, decode-error response for unmapped regions, and a watchdog timeout that converts a hung slave into a bus error.

Parameters:
- NM, 2, number of upstream masters (1..8)
- NS, 4, number of downstream slaves (1..16)
- AW, 32, address width
- DW, 128, data width; SW = DW/8 byte selects
- MSK, 24, slave index = adr[AW-1:MSK]
- TO_CYC, 255, max cycles a strobe may wait for ack/err before timeout (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_wb_adr  in  NM*AW  master addresses, master i at [i*AW +: AW]
- s_wb_sel  in  NM*SW  master byte selects
- s_wb_we  in  NM  master write enables
- s_wb_dat_i  in  NM*DW  master write data
- s_wb_dat_o  out  NM*DW  read data to masters
- s_wb_cyc  in  NM  master cycle
- s_wb_stb  in  NM  master strobe
- s_wb_ack  out  NM  ack to masters
- s_wb_err  out  NM  err to masters
- m_wb_adr  out  AW  address broadcast to slaves
- m_wb_sel  out  SW  byte selects broadcast
- m_wb_we  out  1  write enable broadcast
- m_wb_dat_o  out  DW  write data broadcast
- m_wb_dat_i  in  NS*DW  slave read data
- m_wb_cyc  out  NS  per-slave cycle
- m_wb_stb  out  NS  per-slave strobe
- m_wb_ack  in  NS  slave acks
- m_wb_err  in  NS  slave errs
- o_grant  out  NM  one-hot current grant (debug)
- o_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset:
  - state IDLE; all outputs 0.
  - Round-robin pointer last = NM-1, so master 0 wins first.
  - Watchdog counter 0.
- States: IDLE, GRANT, DECERR, TOERR.
- IDLE:
  - No grant; m_wb_* all 0.
  - If any s_wb_cyc is set, grant the first requester searching last+1, last+2, ... modulo NM.
  - Grant is registered: enter GRANT next cycle with o_grant and last updated.
  - One cycle of arbitration latency.
- GRANT (master g):
  - Broadcast adr/sel/we/dat of g to the slave side.
  - idx = s_wb_adr[g][AW-1:MSK].
  - If idx < NS: m_wb_cyc[idx] = s_wb_cyc[g] and m_wb_stb[idx] = s_wb_stb[g], combinationally; other slaves get 0.
  - s_wb_ack[g] = m_wb_ack[idx], s_wb_err[g] = m_wb_err[idx], s_wb_dat_o[g] = m_wb_dat_i[idx], all combinational with zero added latency.
  - Non-granted masters see ack/err/dat = 0.
- Grant hold:
  - Grant is held while s_wb_cyc[g]=1, including gaps with stb=0 and address changes between slaves.
  - When s_wb_cyc[g] falls, go to IDLE the next cycle; no master is starved beyond one full cycle of every other requester.
- Unmapped address:
  - Condition: s_wb_stb[g]=1 with idx >= NS.
  - No slave is strobed; enter DECERR.
  - DECERR asserts s_wb_err[g]=1 for exactly one cycle, then returns to GRANT.
  - Err reaches the master 1 cycle after the strobe is presented.
- Watchdog:
  - Counter increments each GRANT cycle with s_wb_stb[g]=1 and no ack/err from the selected slave.
  - Clears on ack, err, stb=0, or state change.
  - When the counter reaches TO_CYC, enter TOERR.
  - TOERR forces m_wb_cyc/stb to 0, asserts s_wb_err[g] and o_timeout for one cycle, then returns to GRANT.
  - A slave ack arriving in the TOERR cycle is dropped.
- Simultaneous events:
  - Slave ack and err together pass through unchanged; slaves must not do this.
  - A new request arriving in the same cycle as the current owner drops cyc is handled after the IDLE cycle.
- Reset mid-operation: on the next edge everything returns to reset values; the outstanding slave cycle is abandoned (cyc dropped).
- Widths:
  - idx is AW-MSK bits and is compared unsigned.
  - Watchdog counter is clog2(TO_CYC+1) bits and saturates at TO_CYC.

Test Plan:
- Single master read:
  - Stimulus: master 0 reads 0x0100_0010 with NS=4, MSK=24.
  - Response: m_wb_stb=4'b0010.
  - Slave 1 acks with data 0xA5..A5; master 0 sees ack with that data in the same cycle.
  - Grant asserted 1 cycle after cyc.
- Round-robin:
  - Stimulus: masters 0 and 1 both hold cyc and each issue 3 back-to-back single transfers, releasing cyc between transfers.
  - Response: grant order 0,1,0,1,0,1.
  - Each IDLE gap is exactly 1 cycle.
- Decode error:
  - Stimulus: master 1 strobes 0x0400_0000 (idx 4).
  - Response: no m_wb_stb bit set; s_wb_err[1]=1 exactly 1 cycle later, for 1 cycle.
  - Grant is kept.
- Watchdog:
  - Stimulus: slave 2 never acks, TO_CYC=8.
  - Response: after 8 strobe cycles, m_wb_cyc[2] drops; s_wb_err[g] and o_timeout pulse for 1 cycle.
  - A following transfer to slave 0 completes normally.
- Grant hold:
  - Stimulus: master 0 keeps cyc across 4 transfers alternating slave 0 and slave 3, while master 1 requests.
  - Response: master 1 is not granted until master 0 drops cyc, then is granted after 1 IDLE cycle.
- Reset mid-transfer:
  - Stimulus: assert rst while slave 1 is strobed.
  - Response: next edge m_wb_cyc/stb=0, o_grant=0, and after release master 0 wins first arbitration.
